mul_share_arbiter: RTL and testbench

Round-robin arbiter that time-shares one pipelined 8x8 unsigned multiplier (registered inputs, registered 16-bit product) among N requesters. Each requester presents operands with a valid/ready handshake. The arbiter issues at most one operation per cycle, tracks in-flight requester IDs through a tag pipeline matched to the multiplier latency, and returns each product with its owner's ID. It sits between the requesting datapath blocks and the single multiplier instance and also drives the multiplier's reset.

---
 rtl/mul_share_arbiter_if.sv | 26 ++
 rtl/mul_share_arbiter.sv | 116 +++++++++++
 tb/tb_mul_share_arbiter.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/mul_share_arbiter_if.sv
// Requester-side bus of the shared multiplier arbiter: operand requests in,
// grants and tagged products out.
interface mul_share_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int W     = 8
) ();
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ*W-1:0] req_a;
  logic [N_REQ*W-1:0] req_b;
  logic [N_REQ-1:0]   req_ready;
  logic               rsp_valid;
  logic [ID_W-1:0]    rsp_id;
  logic [2*W-1:0]     rsp_data;

  modport master (
    output req_valid, req_a, req_b,
    input  req_ready, rsp_valid, rsp_id, rsp_data
  );

  modport slave (
    input  req_valid, req_a, req_b,
    output req_ready, rsp_valid, rsp_id, rsp_data
  );
endinterface

// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter time-sharing one pipelined multiplier among N_REQ
// requesters; a tag pipe tracks the owner of each in-flight product.
module mul_share_arbiter #(
  parameter int N_REQ   = 4,
  parameter int W       = 8,
  parameter int MUL_LAT = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  mul_share_arbiter_if.slave bus,
  output logic               mul_reset,
  output logic [W-1:0]       mul_a,
  output logic [W-1:0]       mul_b,
  input  logic [2*W-1:0]     mul_p,
  output logic               busy
);
  localparam int ID_W = $clog2(N_REQ);

  logic [ID_W-1:0]    ptr_r;
  logic [ID_W-1:0]    grant_id_s;
  logic               grant_found_s;
  logic               grant_valid_s;
  logic               hs_s;
  logic [MUL_LAT-1:0] tag_valid_r;
  logic [ID_W-1:0]    tag_id_r [MUL_LAT];
  logic               rsp_valid_r;
  logic [ID_W-1:0]    rsp_id_r;
  logic [2*W-1:0]     rsp_data_r;
  logic               busy_r;

  // Index base+off modulo N_REQ; off is always below N_REQ.
  function automatic logic [ID_W-1:0] rot_idx(input logic [ID_W-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= N_REQ) begin
      sum = sum - N_REQ;
    end else begin
      sum = sum;
    end
    return ID_W'(sum);
  endfunction

  assign mul_reset     = ~reset;
  assign grant_valid_s = reset & en & grant_found_s;
  assign hs_s          = |(bus.req_ready & bus.req_valid);
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_id    = rsp_id_r;
  assign bus.rsp_data  = rsp_data_r;
  assign busy          = busy_r;

  // Round-robin search from ptr; scanning downwards lets the nearest valid win.
  always_comb begin
    grant_found_s = 1'b0;
    grant_id_s    = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (bus.req_valid[rot_idx(ptr_r, k)]) begin
        grant_found_s = 1'b1;
        grant_id_s    = rot_idx(ptr_r, k);
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // Grant vector and operand mux towards the multiplier.
  always_comb begin
    bus.req_ready = '0;
    mul_a         = '0;
    mul_b         = '0;
    if (grant_valid_s) begin
      bus.req_ready[grant_id_s] = 1'b1;
      mul_a = bus.req_a[int'(grant_id_s)*W +: W];
      mul_b = bus.req_b[int'(grant_id_s)*W +: W];
    end else begin
      bus.req_ready = '0;
    end
  end

  // Pointer, owner tag pipe, response register and busy flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr_r       <= '0;
      tag_valid_r <= '0;
      for (int i = 0; i < MUL_LAT; i++) begin
        tag_id_r[i] <= '0;
      end
      rsp_valid_r <= 1'b0;
      rsp_id_r    <= '0;
      rsp_data_r  <= '0;
      busy_r      <= 1'b0;
    end else begin
      if (hs_s) begin
        ptr_r <= rot_idx(grant_id_s, 1);
      end else begin
        ptr_r <= ptr_r;
      end
      tag_valid_r[0] <= hs_s;
      tag_id_r[0]    <= grant_id_s;
      for (int i = 1; i < MUL_LAT; i++) begin
        tag_valid_r[i] <= tag_valid_r[i-1];
        tag_id_r[i]    <= tag_id_r[i-1];
      end
      rsp_valid_r <= tag_valid_r[MUL_LAT-1];
      if (tag_valid_r[MUL_LAT-1]) begin
        rsp_id_r   <= tag_id_r[MUL_LAT-1];
        rsp_data_r <= mul_p;
      end else begin
        rsp_id_r   <= rsp_id_r;
        rsp_data_r <= rsp_data_r;
      end
      // The op leaving the last stage counts until its response cycle ends.
      busy_r <= hs_s | (|tag_valid_r);
    end
  end
endmodule

// File: tb/tb_mul_share_arbiter.sv
// Bench for mul_share_arbiter: directed scenarios plus random traffic,
// checked against a queue-based model of grants and responses.
module tb_mul_share_arbiter;
  localparam int N   = 4;
  localparam int W   = 8;
  localparam int LAT = 2;

  typedef struct {
    int id;
    int prod;
    int issue;
  } op_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        mul_reset;
  logic [7:0]  mul_a, mul_b;
  logic [15:0] mul_p;
  logic        busy;
  logic [7:0]  ma, mb;

  int n_checks = 0;
  int n_errors = 0;

  op_t q[$];
  int  edge_n  = 0;
  int  m_ptr   = 0;
  int  m_rv    = 0;
  int  m_rid   = 0;
  int  m_rdata = 0;
  int  m_busy  = 0;
  int  g_valid, g_id, g_a, g_b;

  mul_share_arbiter_if #(.N_REQ(N), .W(W)) bus ();

  mul_share_arbiter #(.N_REQ(N), .W(W), .MUL_LAT(LAT)) dut (
    .clk(clk), .reset(reset), .en(en), .bus(bus),
    .mul_reset(mul_reset), .mul_a(mul_a), .mul_b(mul_b),
    .mul_p(mul_p), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural multiplier: operand registers, then product register.
  always @(posedge clk) begin
    if (mul_reset) begin
      ma <= 8'd0; mb <= 8'd0; mul_p <= 16'd0;
    end else begin
      ma <= mul_a; mb <= mul_b; mul_p <= ma * mb;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  // Expected grant for the current inputs: first valid at or after the pointer.
  task automatic model_grant();
    g_valid = 0; g_id = 0; g_a = 0; g_b = 0;
    if (reset === 1'b1 && en === 1'b1) begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_ptr + k) % N;
        if (bus.req_valid[idx]) begin
          g_valid = 1;
          g_id    = idx;
          g_a     = (bus.req_a >> (8 * idx)) & 32'hFF;
          g_b     = (bus.req_b >> (8 * idx)) & 32'hFF;
          break;
        end
      end
    end
  endtask

  // Model update at a rising edge: ops respond LAT edges after acceptance.
  task automatic model_edge();
    edge_n++;
    if (reset !== 1'b1) begin
      q.delete();
      m_ptr = 0; m_rv = 0; m_rid = 0; m_rdata = 0; m_busy = 0;
    end else begin
      while (q.size() > 0 && q[0].issue + LAT < edge_n) void'(q.pop_front());
      if (g_valid != 0) begin
        q.push_back('{g_id, g_a * g_b, edge_n});
        m_ptr = (g_id + 1) % N;
      end
      if (q.size() > 0 && q[0].issue + LAT == edge_n) begin
        m_rv = 1; m_rid = q[0].id; m_rdata = q[0].prod;
      end else begin
        m_rv = 0;
      end
      m_busy = (q.size() > 0) ? 1 : 0;
    end
  endtask

  task automatic run_cycle(input logic v_rst, input logic v_en, input logic [3:0] v_valid,
                           input logic [31:0] v_a, input logic [31:0] v_b);
    logic [3:0] exp_ready;
    reset = v_rst; en = v_en;
    bus.req_valid = v_valid; bus.req_a = v_a; bus.req_b = v_b;
    @(negedge clk);
    model_grant();
    exp_ready = (g_valid != 0) ? (4'b0001 << g_id) : 4'b0000;
    check_eq("req_ready", {28'd0, bus.req_ready}, {28'd0, exp_ready});
    check_eq("mul_a", {24'd0, mul_a}, g_a);
    check_eq("mul_b", {24'd0, mul_b}, g_b);
    check_eq("mul_reset", {31'd0, mul_reset}, {31'd0, ~v_rst});
    check_eq("rsp_valid", {31'd0, bus.rsp_valid}, m_rv);
    check_eq("rsp_id", {30'd0, bus.rsp_id}, m_rid);
    check_eq("rsp_data", {16'd0, bus.rsp_data}, m_rdata);
    check_eq("busy", {31'd0, busy}, m_busy);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    reset = 1'b0; en = 1'b0;
    bus.req_valid = 4'd0; bus.req_a = 32'd0; bus.req_b = 32'd0;
    @(posedge clk); #1;
    run_cycle(1'b0, 1'b1, 4'b1111, 32'h0102_0304, 32'h0506_0708);

    // Single op from requester 2: 0xFF * 0xFF
    run_cycle(1'b1, 1'b1, 4'b0100, 32'h00FF_0000, 32'h00FF_0000);
    for (int i = 0; i < 4; i++) run_cycle(1'b1, 1'b1, 4'b0000, 32'd0, 32'd0);

    // All four continuously, A=i+1, B=3
    for (int i = 0; i < 8; i++) run_cycle(1'b1, 1'b1, 4'b1111, 32'h0403_0201, 32'h0303_0303);
    for (int i = 0; i < 3; i++) run_cycle(1'b1, 1'b1, 4'b0000, 32'd0, 32'd0);

    // Fairness between requesters 0 and 3
    for (int i = 0; i < 6; i++) run_cycle(1'b1, 1'b1, 4'b1001, 32'h1100_0022, 32'h0500_0007);

    // en low for four cycles under full load, then resume
    for (int i = 0; i < 12; i++)
      run_cycle(1'b1, (i >= 4 && i < 8) ? 1'b0 : 1'b1, 4'b1111, 32'h8040_2010, 32'h0203_0405);
    for (int i = 0; i < 3; i++) run_cycle(1'b1, 1'b1, 4'b0000, 32'd0, 32'd0);

    // Reset mid-flight
    run_cycle(1'b1, 1'b1, 4'b0110, 32'h0033_4400, 32'h0055_6600);
    run_cycle(1'b1, 1'b1, 4'b0110, 32'h0033_4400, 32'h0055_6600);
    run_cycle(1'b0, 1'b1, 4'b0110, 32'h0033_4400, 32'h0055_6600);
    for (int i = 0; i < 4; i++) run_cycle(1'b1, 1'b1, 4'b1111, 32'h0909_0909, 32'h0A0A_0A0A);

    // Zero operand from requester 1
    for (int i = 0; i < 3; i++) run_cycle(1'b1, 1'b1, 4'b0000, 32'd0, 32'd0);
    run_cycle(1'b1, 1'b1, 4'b0010, 32'h0000_0000, 32'h0000_A500);
    for (int i = 0; i < 3; i++) run_cycle(1'b1, 1'b1, 4'b0000, 32'd0, 32'd0);

    // Random traffic
    for (int i = 0; i < 400; i++)
      run_cycle(($urandom_range(0, 40) != 0) ? 1'b1 : 1'b0,
                ($urandom_range(0, 7) != 0) ? 1'b1 : 1'b0,
                4'($urandom_range(0, 15)), $urandom, $urandom);
    for (int i = 0; i < 4; i++) run_cycle(1'b1, 1'b1, 4'b0000, 32'd0, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
